// File: rtl/rv_pkg.sv
// rv_pkg: core-wide RV32I widths and register-address type
package rv_pkg;
   localparam int REG_COUNT  = 32;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/riscv_register_file.sv
// riscv_register_file: 32x32 integer register file, two async read ports, one sync write port, x0 hardwired to zero
module riscv_register_file
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  reg_addr_t       read_address1,
   output logic [XLEN-1:0] read_data1,
   input  reg_addr_t       read_address2,
   output logic [XLEN-1:0] read_data2,
   input  reg_addr_t       write_address,
   input  logic [XLEN-1:0] write_data,
   input  logic            write_enable
);
   // entry 0 is cleared on reset and never written; reads of x0 are masked anyway
   logic [XLEN-1:0] regs [REG_COUNT];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (write_enable && write_address != '0) begin
         regs[write_address] <= write_data;
      end
   end
   always_comb read_data1 = (read_address1 == '0) ? '0 : regs[read_address1];
   always_comb read_data2 = (read_address2 == '0) ? '0 : regs[read_address2];
endmodule

// File: tb/tb_riscv_register_file.sv
// tb_riscv_register_file: directed table-driven checks plus same-cycle and reset-with-write sequences
module tb_riscv_register_file;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  read_address1, read_address2, write_address;
   logic [31:0] read_data1, read_data2, write_data;
   logic        write_enable;
   int          errors = 0;
   int          checks = 0;

   riscv_register_file dut (
      .clk(clk), .rst(rst),
      .read_address1(read_address1), .read_data1(read_data1),
      .read_address2(read_address2), .read_data2(read_data2),
      .write_address(write_address), .write_data(write_data),
      .write_enable(write_enable)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 5'd3,  32'hFFFF_FFFF, 5'd0,  5'd1,  32'h0,         32'h0};
      vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'h0,         32'h0};
      vecs[2] = '{1'b0, 1'b1, 5'd1,  32'hDEAD_BEEF, 5'd1,  5'd31, 32'hDEAD_BEEF, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 5'd2,  32'hCAFE_BABE, 5'd1,  5'd2,  32'hDEAD_BEEF, 32'hCAFE_BABE};
      vecs[4] = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd2,  32'h0,         32'hCAFE_BABE};
      vecs[5] = '{1'b0, 1'b0, 5'd2,  32'h1234_5678, 5'd2,  5'd1,  32'hCAFE_BABE, 32'hDEAD_BEEF};
      vecs[6] = '{1'b0, 1'b1, 5'd31, 32'h0F0F_0F0F, 5'd31, 5'd31, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
      vecs[7] = '{1'b0, 1'b1, 5'd5,  32'h1111_1111, 5'd5,  5'd0,  32'h1111_1111, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 5'd5,  32'hFFFF_0000, 5'd3,  5'd5,  32'h0,         32'h1111_1111};
      rst = 1'b0; write_enable = 1'b0; write_address = '0; write_data = '0;
      read_address1 = '0; read_address2 = '0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; write_enable = vecs[i].we; write_address = vecs[i].wa;
         write_data = vecs[i].wd; read_address1 = vecs[i].ra1; read_address2 = vecs[i].ra2;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
         check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
      end
      // same-cycle read/write of x5: old value before the edge, new value after
      @(negedge clk);
      rst = 1'b0; write_enable = 1'b1; write_address = 5'd5; write_data = 32'hA5A5_A5A5;
      read_address1 = 5'd5; read_address2 = 5'd5;
      #1;
      check("rw_same_pre_rd1", read_data1, 32'h1111_1111);
      check("rw_same_pre_rd2", read_data2, 32'h1111_1111);
      @(posedge clk);
      #1;
      check("rw_same_post_rd1", read_data1, 32'hA5A5_A5A5);
      check("rw_same_post_rd2", read_data2, 32'hA5A5_A5A5);
      // reset together with a write: reset wins, every register reads zero
      @(negedge clk);
      rst = 1'b1; write_enable = 1'b1; write_address = 5'd7; write_data = 32'h7777_7777;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0; write_enable = 1'b0;
      for (int a = 0; a < 32; a++) begin
         read_address1 = a[4:0];
         read_address2 = 5'(31 - a);
         #1;
         check($sformatf("rst_wr_rd1_x%0d", a), read_data1, 32'h0);
         check($sformatf("rst_wr_rd2_x%0d", 31 - a), read_data2, 32'h0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
